fp_to_int_seq: RTL and testbench

FP_TO_INT_SEQ -- requirements
Module: fp_to_int_seq

---
 rtl/fp_to_int_seq.sv | 128 ++++++++++++
 tb/tb_fp_to_int_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_seq.sv
// fp_to_int_seq: converts a 13-bit (sign, exponent e, fraction 0.f) value to an 8-bit sign-magnitude integer.
// Latency: done_tick arrives 9-e cycles after the start-sampling cycle for e<8, one cycle after it for e>=8.
// Backpressure: start is honoured only while ready=1; requests made while busy are dropped. Optional macro FP2INT_ROUND_EN.
module fp_to_int_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] fp,
  output logic        ready,
  output logic        done_tick,
  output logic [7:0]  integ,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q;
  logic        ready_q;
  logic        done_q;
  logic [7:0]  integ_q;
  logic        ovf_q;
  logic        sign_q;
  logic [7:0]  mag_q;
  logic [3:0]  count_q;
`ifdef FP2INT_ROUND_EN
  logic        guard_q;
  logic [8:0]  shift_d;     // {mag, guard} after one more right shift
`else
  logic [7:0]  shift_d;     // mag after one more right shift
`endif
  logic [8:0]  fin_mag_d;   // magnitude as it will stand on the edge into DONE
  logic [8:0]  direct_res_d;
  logic [8:0]  shift_res_d;

  // Saturate to 127 when forced or when the magnitude does not fit, and suppress negative zero.
  // Returns {ovf, sign, magnitude[6:0]}.
  function automatic logic [8:0] pack_result(input logic s, input logic [8:0] m, input logic force_sat);
    logic [6:0] m7;
    logic       o;
    if (force_sat || (m > 9'd127)) begin
      m7 = 7'h7F;
      o  = 1'b1;
    end else begin
      m7 = m[6:0];
      o  = 1'b0;
    end
    return {o, s & (m7 != 7'd0), m7};
  endfunction

  // Next shift step and the two possible results (large exponent taken directly, small exponent after shifting).
  always_comb begin
`ifdef FP2INT_ROUND_EN
    shift_d   = {mag_q, guard_q} >> 1;
    fin_mag_d = {1'b0, shift_d[8:1]} + {8'd0, shift_d[0]};
`else
    shift_d   = mag_q >> 1;
    fin_mag_d = {1'b0, shift_d};
`endif
    direct_res_d = pack_result(fp[12], {1'b0, fp[7:0]}, fp[11:8] > 4'd8);
    shift_res_d  = pack_result(sign_q, fin_mag_d, 1'b0);
  end

  // Control FSM with registered outputs; result registers load only on the edge into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      integ_q <= 8'h00;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= 8'h00;
      count_q <= 4'd0;
`ifdef FP2INT_ROUND_EN
      guard_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= fp[12];
            ready_q <= 1'b0;
            if (fp[11:8] < 4'd8) begin
              mag_q   <= fp[7:0];
              count_q <= 4'd8 - fp[11:8];
`ifdef FP2INT_ROUND_EN
              guard_q <= 1'b0;
`endif
              state_q <= SHIFT;
            end else begin
              {ovf_q, integ_q} <= direct_res_d;
              done_q           <= 1'b1;
              state_q          <= DONE;
            end
          end
        end
        SHIFT: begin
`ifdef FP2INT_ROUND_EN
          {mag_q, guard_q} <= shift_d;
`else
          mag_q <= shift_d;
`endif
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            {ovf_q, integ_q} <= shift_res_d;
            done_q           <= 1'b1;
            state_q          <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done_tick = done_q;
  assign integ     = integ_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Bench for fp_to_int_seq: value-level model (f * 2^e / 256) plus directed vectors with literal expectations.
module tb_fp_to_int_seq;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [12:0] fp    = 13'h0000;
  logic        ready;
  logic        done_tick;
  logic [7:0]  integ;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FP2INT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  fp_to_int_seq dut (
    .clk(clk), .reset(reset), .start(start), .fp(fp),
    .ready(ready), .done_tick(done_tick), .integ(integ), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {ovf, integ} from the numeric value |x| = f * 2^e / 256.
  function automatic int model_conv(input logic [12:0] v);
    int e, f, m, s;
    e = int'(v[11:8]);
    f = int'(v[7:0]);
    if (e > 8) m = 128;
    else if (RND) m = (f * (1 << e) + 128) / 256;
    else m = (f * (1 << e)) / 256;
    if (m > 127) return 256 | (v[12] ? 128 : 0) | 127;
    s = (v[12] && m != 0) ? 128 : 0;
    return s | m;
  endfunction

  function automatic int model_lat(input logic [12:0] v);
    int e;
    e = int'(v[11:8]);
    return (e < 8) ? (9 - e) : 1;
  endfunction

  // Model timeline: which cycle the single outstanding request completes in, and the held result.
  int cyc        = 0;
  int busy_until = -1;
  bit pend_vld   = 1'b0;
  int pend_cyc   = 0;
  int pend_res   = 0;
  int held_res   = 0;

  always @(posedge clk) begin
    if (reset) begin
      busy_until = -1;
      pend_vld   = 1'b0;
      held_res   = 0;
    end else begin
      if (pend_vld && cyc == pend_cyc) begin
        held_res = pend_res;
        pend_vld = 1'b0;
      end
      if (start && cyc > busy_until) begin
        pend_vld   = 1'b1;
        pend_cyc   = cyc + model_lat(fp);
        pend_res   = model_conv(fp);
        busy_until = pend_cyc;
      end
    end
    cyc++;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    bit exp_done;
    int exp_res;
    if (reset) begin
      chk($sformatf("rst_ready@%0d", cyc), ready, 1);
      chk($sformatf("rst_done@%0d", cyc), done_tick, 0);
      chk($sformatf("rst_integ@%0d", cyc), integ, 0);
      chk($sformatf("rst_ovf@%0d", cyc), ovf, 0);
    end else begin
      exp_done = pend_vld && (cyc == pend_cyc);
      exp_res  = exp_done ? pend_res : held_res;
      chk($sformatf("ready@%0d", cyc), ready, int'(cyc > busy_until));
      chk($sformatf("done_tick@%0d", cyc), done_tick, int'(exp_done));
      chk($sformatf("integ@%0d", cyc), integ, exp_res & 255);
      chk($sformatf("ovf@%0d", cyc), ovf, (exp_res >> 8) & 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!ready && k < 20) begin
      tick();
      k++;
    end
    chk({nm, "_ready"}, ready, 1);
  endtask

  task automatic run_vec(input logic [12:0] v, input logic [7:0] exp_i, input logic exp_o,
                         input int exp_lat, input string nm);
    int k;
    bit seen;
    wait_ready(nm);
    fp    = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    k     = 1;
    seen  = 1'b0;
    while (k <= 12) begin
      if (done_tick) begin
        seen = 1'b1;
        break;
      end
      tick();
      k++;
    end
    chk({nm, "_lat"}, seen ? k : -1, exp_lat);
    chk({nm, "_integ"}, integ, exp_i);
    chk({nm, "_ovf"}, ovf, exp_o);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    int ndone;
    int last;
    #1 reset = 1'b1;
    #1;
    chk("por_ready", ready, 1);
    chk("por_done", done_tick, 0);
    chk("por_integ", integ, 0);
    chk("por_ovf", ovf, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_vec(13'h04F0, 8'h0F, 1'b0, 5, "e4_f0");
    run_vec(13'h17FE, 8'hFF, 1'b0, 2, "neg_e7_fe");
    run_vec(13'h07FF, 8'h7F, RND,  2, "e7_ff");
    run_vec(13'h0980, 8'h7F, 1'b1, 1, "e9_sat");
    run_vec(13'h1855, 8'hD5, 1'b0, 1, "neg_e8_55");
    run_vec(13'h1080, RND ? 8'h81 : 8'h00, 1'b0, 9, "neg_e0_80");
    run_vec(13'h1880, 8'hFF, 1'b1, 1, "neg_e8_80_sat");
    run_vec(13'h03B0, RND ? 8'h06 : 8'h05, 1'b0, 6, "e3_b0");
    run_vec(13'h1800, 8'h00, 1'b0, 1, "neg_zero");
    run_vec(13'h1F01, 8'hFF, 1'b1, 1, "neg_e15_sat");
    run_vec(13'h0641, 8'h10, 1'b0, 3, "e6_41");

    // Abort: second start ignored while busy, reset mid-shift produces no done_tick.
    wait_ready("abort");
    fp    = 13'h0180;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    fp    = 13'h04F0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy", ready, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_rst_ready", ready, 1);
    chk("abort_rst_integ", integ, 0);
    chk("abort_rst_done", done_tick, 0);
    tick();
    tick();
    reset  = 1'b0;
    dcount = 0;
    repeat (12) begin
      tick();
      if (done_tick) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    chk("abort_idle_ready", ready, 1);

    // start held high: one conversion every three cycles.
    fp    = 13'h07C0;
    start = 1'b1;
    ndone = 0;
    last  = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done_tick) begin
        ndone++;
        chk("held_integ", integ, 8'h60);
        chk("held_ovf", ovf, 0);
        if (last < 0) chk("held_first_lat", k, 2);
        else chk("held_gap", k - last, 3);
        last = k;
      end
    end
    start = 1'b0;
    chk("held_count", ndone, 4);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
